keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan_pkg.sv | 61 ++++++
 rtl/keypad_scan_sync2.sv | 33 +++
 rtl/keypad_scan.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_scan.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - scan_state_t : FSM state encodings (SCAN, DEBOUNCE, HELD, RELEASE)
//   - ROW_RESET    : row drive pattern after reset (row 0 driven low)
//   - KEYMAP       : hex code per (row, col), indexed by {row, col}
//   - helper functions to look up a key, encode the driven row and pick the
//     lowest-index active column
// -----------------------------------------------------------------------------
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Physical layout:
    //   row0: 1 2 3 A
    //   row1: 4 5 6 B
    //   row2: 7 8 9 C
    //   row3: E 0 F D
    localparam logic [3:0] KEYMAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] keymap_lookup(input logic [1:0] row,
                                                 input logic [1:0] col);
        return KEYMAP[{row, col}];
    endfunction

    // Index of the single low bit in the active-low row drive.
    function automatic logic [1:0] row_index(input logic [3:0] row);
        logic [1:0] idx;
        case (row)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest-index low column wins when several keys share the driven row.
    function automatic logic [1:0] lowest_low(input logic [3:0] col);
        logic [1:0] idx;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer, 4 bits wide, for the asynchronous column inputs.
// Resets to 4'hF (no key pressed, columns are active-low).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   d    - asynchronous input
//   q    - synchronized output
// -----------------------------------------------------------------------------
module sync2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= 4'hF;
            sync_reg <= 4'hF;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner with debounce and an 8-digit entry buffer.
// Rows are driven one at a time (active-low) and advance on each scan tick
// while no column is low. A detected key must stay stable for DEB_TICKS ticks
// to be accepted, and its release must be stable for DEB_TICKS ticks before
// scanning resumes.
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   defined   - while a key is held, key_valid re-pulses every REPEAT_TICKS
//               ticks with the same code, shifting digits again each time.
//   undefined - exactly one key_valid per press; no repeat counter exists.
//
// Parameters:
//   SCAN_DIV_W   - tick every 2^SCAN_DIV_W clk cycles
//   DEB_TICKS    - stable ticks to accept a press or release
//   REPEAT_TICKS - auto-repeat interval in ticks
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   row_out   - row drive, active-low, exactly one bit low
//   col_in    - column sense, active-low, asynchronous
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle pulse per accepted key event
//   key_held  - high while an accepted key remains pressed
//   digits    - 8-nibble entry buffer, [3:0] newest
// -----------------------------------------------------------------------------
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV_W   = 16,
    parameter int DEB_TICKS    = 16,
    parameter int REPEAT_TICKS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] digits
);

    localparam int               DEB_W    = $clog2(DEB_TICKS + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS);

    if (SCAN_DIV_W < 1 || DEB_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_scan: SCAN_DIV_W, DEB_TICKS and REPEAT_TICKS must be >= 1");
    end

    logic [3:0] col_s;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (col_in),
        .q   (col_s)
    );

    scan_state_t              state_reg, state_next;
    logic [SCAN_DIV_W-1:0]    div_reg;
    logic [3:0]               row_reg, row_next;
    logic [1:0]               row_idx_reg, row_idx_next;
    logic [1:0]               col_idx_reg, col_idx_next;
    logic [DEB_W-1:0]         deb_reg, deb_next, deb_inc;
    logic [3:0]               code_reg, code_next;
    logic                     valid_reg, valid_next;
    logic                     held_reg, held_next;
    logic [31:0]              digits_reg, digits_next;
    logic                     tick;
    logic                     col_high;
    logic                     accept;

`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);
    logic [REP_W-1:0]            rep_reg, rep_next, rep_inc;
`endif

    // Tick fires in the cycle where the divider wraps back to zero.
    assign tick = &div_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + SCAN_DIV_W'(1);
        end
    end

    // State register and all datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_SCAN;
            row_reg     <= ROW_RESET;
            row_idx_reg <= 2'd0;
            col_idx_reg <= 2'd0;
            deb_reg     <= '0;
            code_reg    <= 4'h0;
            valid_reg   <= 1'b0;
            held_reg    <= 1'b0;
            digits_reg  <= 32'h0;
`ifdef KEYPAD_REPEAT_EN
            rep_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            row_reg     <= row_next;
            row_idx_reg <= row_idx_next;
            col_idx_reg <= col_idx_next;
            deb_reg     <= deb_next;
            code_reg    <= code_next;
            valid_reg   <= valid_next;
            held_reg    <= held_next;
            digits_reg  <= digits_next;
`ifdef KEYPAD_REPEAT_EN
            rep_reg     <= rep_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        row_idx_next = row_idx_reg;
        col_idx_next = col_idx_reg;
        deb_next     = deb_reg;
        code_next    = code_reg;
        valid_next   = 1'b0;
        held_next    = held_reg;
        digits_next  = digits_reg;
        accept       = 1'b0;
        deb_inc      = deb_reg + DEB_W'(1);
        // Only the latched column matters once a key has been detected.
        col_high     = col_s[col_idx_reg];
`ifdef KEYPAD_REPEAT_EN
        rep_next     = rep_reg;
        rep_inc      = rep_reg + REP_W'(1);
`endif

        if (tick) begin
            case (state_reg)
                ST_SCAN: begin
                    if (col_s == 4'hF) begin
                        row_next = {row_reg[2:0], row_reg[3]};
                    end else begin
                        // Row stays where it is so the key remains visible.
                        row_idx_next = row_index(row_reg);
                        col_idx_next = lowest_low(col_s);
                        deb_next     = '0;
                        state_next   = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!col_high) begin
                        deb_next = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            accept     = 1'b1;
                            held_next  = 1'b1;
                            state_next = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_next   = '0;
`endif
                        end
                    end else begin
                        state_next = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (col_high) begin
                        deb_next   = '0;
                        state_next = ST_RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_inc == REP_LAST) begin
                        accept   = 1'b1;
                        rep_next = '0;
                    end else begin
                        rep_next = rep_inc;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (col_high) begin
                        deb_next = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            held_next  = 1'b0;
                            state_next = ST_SCAN;
                        end
                    end else begin
                        // Release bounced: key still down.
                        state_next = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_next   = '0;
`endif
                    end
                end
                default: state_next = ST_SCAN;
            endcase
        end

        // Code, buffer and pulse all register on the same edge.
        if (accept) begin
            code_next   = keymap_lookup(row_idx_reg, col_idx_reg);
            digits_next = {digits_reg[27:0], code_next};
            valid_next  = 1'b1;
        end
    end

    assign row_out   = row_reg;
    assign key_code  = code_reg;
    assign key_valid = valid_reg;
    assign key_held  = held_reg;
    assign digits    = digits_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
// Self-checking bench for keypad_scan (SCAN_DIV_W=2, DEB_TICKS=3,
// REPEAT_TICKS=4). A keypad matrix model turns a 16-bit "pressed" mask into
// column levels from the driven row. Expected key events are queued when a
// key is pressed and popped when key_valid is seen.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

    localparam int SCAN_DIV_W   = 2;
    localparam int DEB_TICKS    = 3;
    localparam int REPEAT_TICKS = 4;
`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD_EXTRA = 4;
`else
    localparam int HOLD_EXTRA = 30;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] digits;
    logic [15:0] pressed = 16'h0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV_W   (SCAN_DIV_W),
        .DEB_TICKS    (DEB_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_out   (row_out),
        .col_in    (col_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digits    (digits)
    );

    // Keypad matrix: a pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [3:0]  code;
        logic [31:0] dig;
    } exp_t;

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  code;
    } key_vec_t;

    exp_t        exp_q [$];
    logic [31:0] exp_digits = 32'h0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: row drive shape every cycle, and scoreboard on each key event.
    always @(negedge clk) begin
        if (rst) begin
            check("row_out_one_low", 32'($countones(row_out)), 32'd3);
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_key_valid", {28'h0, key_code}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("key event: code=%h digits=%h (expected code=%h digits=%h)",
                             key_code, digits, e.code, e.dig);
                    check("key_code", {28'h0, key_code}, {28'h0, e.code});
                    check("digits", digits, e.dig);
                end
            end
        end
    end

    task automatic push_expect(input logic [3:0] code);
        exp_t e;
        exp_digits = {exp_digits[27:0], code};
        e.code = code;
        e.dig  = exp_digits;
        exp_q.push_back(e);
    endtask

    task automatic wait_held(input logic val, input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (key_held === val) break;
        end
        check(name, {31'h0, key_held}, {31'h0, val});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic press_key(input logic [15:0] mask, input logic [3:0] code);
        push_expect(code);
        pressed = mask;
        wait_held(1'b1, "key_held_set");
        wait_drain("key_valid_seen");
        repeat (HOLD_EXTRA) @(negedge clk);
        pressed = 16'h0;
        wait_held(1'b0, "key_held_clear");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_out"},   {28'h0, row_out},   32'h0000_000E);
        check({tag, "_key_code"},  {28'h0, key_code},  32'h0);
        check({tag, "_key_valid"}, {31'h0, key_valid}, 32'h0);
        check({tag, "_key_held"},  {31'h0, key_held},  32'h0);
        check({tag, "_digits"},    digits,             32'h0);
    endtask

    key_vec_t   tbl [18];
    logic [3:0] row_seq [4];
    int         n;
    logic [3:0] prev;

    initial begin
        tbl[0]  = '{16'h0001, 4'h1};
        tbl[1]  = '{16'h0002, 4'h2};
        tbl[2]  = '{16'h0004, 4'h3};
        tbl[3]  = '{16'h0010, 4'h4};
        tbl[4]  = '{16'h0020, 4'h5};
        tbl[5]  = '{16'h0040, 4'h6};
        tbl[6]  = '{16'h0100, 4'h7};
        tbl[7]  = '{16'h0200, 4'h8};
        tbl[8]  = '{16'h0400, 4'h9};
        tbl[9]  = '{16'h0008, 4'hA};
        tbl[10] = '{16'h0080, 4'hB};
        tbl[11] = '{16'h0800, 4'hC};
        tbl[12] = '{16'h1000, 4'hE};
        tbl[13] = '{16'h2000, 4'h0};
        tbl[14] = '{16'h4000, 4'hF};
        tbl[15] = '{16'h8000, 4'hD};
        tbl[16] = '{16'h00A0, 4'h5};   // row1 cols 1 and 3: col 1 wins
        tbl[17] = '{16'h6000, 4'h0};   // row3 cols 1 and 2: col 1 wins
        row_seq[0] = 4'b1110;
        row_seq[1] = 4'b1101;
        row_seq[2] = 4'b1011;
        row_seq[3] = 4'b0111;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Idle rotation: one row step every 4 clocks.
        for (int k = 1; k <= 5; k++) begin
            prev = row_out;
            n = 0;
            while (row_out === prev && n < 12) begin
                @(negedge clk);
                n++;
            end
            check("idle_row_step", {28'h0, row_out}, {28'h0, row_seq[k % 4]});
            if (k > 1) check("idle_step_period", 32'(n), 32'd4);
        end

        // Single key "6".
        press_key(16'h0040, 4'h6);
        check("key6_digits", digits, 32'h0000_0006);
        check("key6_code", {28'h0, key_code}, 32'h6);

        // Bounce: key "2" visible for too few ticks.
        for (n = 0; n < 40 && row_out !== 4'b1101; n++) @(negedge clk);
        for (n = 0; n < 40 && row_out !== 4'b1110; n++) @(negedge clk);
        check("bounce_sync_row0", {28'h0, row_out}, 32'h0000_000E);
        pressed = 16'h0002;
        repeat (10) @(negedge clk);
        pressed = 16'h0;
        for (n = 0; n < 40 && row_out === 4'b1110; n++) @(negedge clk);
        check("bounce_resume_row", {28'h0, row_out}, 32'h0000_000D);
        check("bounce_no_held", {31'h0, key_held}, 32'h0);
        check("bounce_digits", digits, 32'h0000_0006);

        // Key table.
        for (int i = 0; i < 18; i++) begin
            press_key(tbl[i].mask, tbl[i].code);
            if (i == 8) check("digits_after_1_to_9", digits, 32'h2345_6789);
        end
        check("digits_after_table", digits, 32'hBCE0_FD50);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat: key "A" held, first pulse then repeats every 4 ticks.
        push_expect(4'hA);
        pressed = 16'h0008;
        wait_held(1'b1, "repeat_held_set");
        wait_drain("repeat_first_pulse");
        for (int r = 0; r < 2; r++) begin
            push_expect(4'hA);
            for (n = 0; n < 24 && exp_q.size() != 0; n++) @(negedge clk);
            check("repeat_pulse", 32'(exp_q.size()), 32'd0);
            if (r > 0) check("repeat_interval", 32'(n), 32'd16);
        end
        pressed = 16'h0;
        wait_held(1'b0, "repeat_held_clear");
`endif

        // Reset while HELD: immediate clear, no pulse afterwards.
        push_expect(4'h7);
        pressed = 16'h0100;
        wait_held(1'b1, "prereset_held_set");
        wait_drain("prereset_pulse");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("held_reset");
        exp_digits = 32'h0;
        pressed = 16'h0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_no_held", {31'h0, key_held}, 32'h0);
        check("post_reset_digits", digits, 32'h0);
        check("post_reset_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
